// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants for the 800x600 VGA pixel pipeline
package vga_pkg;
  localparam int H_ACTIVE  = 800;
  localparam int V_ACTIVE  = 600;
  localparam int RGB_W     = 12;
  localparam int CNT_W_DEF = 11;
endpackage

// File: rtl/sprite_hit_detect.sv
// rtl/sprite_hit_detect.sv - registered window compare of the pixel position against one sprite
module sprite_hit_detect
  import vga_pkg::*;
#(
  parameter int SPR_W = 48,
  parameter int SPR_H = 64,
  parameter int POS_W = 12,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [POS_W-1:0] x,
  input  logic [POS_W-1:0] y,
  input  logic [CNT_W-1:0] hcount,
  input  logic [CNT_W-1:0] vcount,
  input  logic             blank,
  output logic             hit
);
  localparam int SW = POS_W + 1;

  logic [SW-1:0] h, v, x0, y0, x1, y1;
  logic          hit_c;

  // One extra bit on the right/bottom edges keeps sprites near the coordinate limit from wrapping.
  always_comb begin
    h     = SW'(hcount);
    v     = SW'(vcount);
    x0    = {1'b0, x};
    y0    = {1'b0, y};
    x1    = x0 + SW'(SPR_W);
    y1    = y0 + SW'(SPR_H);
    hit_c = en & ~blank
          & (h >= x0) & (h < x1) & (v >= y0) & (v < y1)
          & (h < SW'(H_ACTIVE)) & (v < SW'(V_ACTIVE));
  end

  always_ff @(posedge clk) begin
    if (rst) hit <= 1'b0;
    else     hit <= hit_c;
  end
endmodule

// File: rtl/vga_sprite_layer.sv
// rtl/vga_sprite_layer.sv - N-sprite overlay with vsync-latched positions and per-frame collision flags
module vga_sprite_layer
  import vga_pkg::*;
#(
  parameter int N_SPRITES = 4,
  parameter int SPR_W     = 48,
  parameter int SPR_H     = 64,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int POS_W     = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CNT_W-1:0]           in_hcount,
  input  logic [CNT_W-1:0]           in_vcount,
  input  logic                       in_hsync,
  input  logic                       in_vsync,
  input  logic                       in_hblnk,
  input  logic                       in_vblnk,
  input  logic [RGB_W-1:0]           in_rgb,
  input  logic [N_SPRITES*POS_W-1:0] xpos,
  input  logic [N_SPRITES*POS_W-1:0] ypos,
  input  logic [N_SPRITES-1:0]       sprite_en,
  input  logic [N_SPRITES*RGB_W-1:0] sprite_rgb,
  output logic [CNT_W-1:0]           out_hcount,
  output logic [CNT_W-1:0]           out_vcount,
  output logic                       out_hsync,
  output logic                       out_vsync,
  output logic                       out_hblnk,
  output logic                       out_vblnk,
  output logic [RGB_W-1:0]           out_rgb,
  output logic [N_SPRITES-1:0]       collision,
  output logic                       frame_tick
);
  logic                       vs_prev, latch, multi;
  logic [N_SPRITES*POS_W-1:0] act_x, act_y;
  logic [N_SPRITES-1:0]       act_en, acc, hit;
  logic [CNT_W-1:0]           hcount_d, vcount_d;
  logic                       hsync_d, vsync_d, hblnk_d, vblnk_d;
  logic [RGB_W-1:0]           rgb_d, sel_rgb;

  assign latch = in_vsync & ~vs_prev;

  for (genvar i = 0; i < N_SPRITES; i++) begin : g_hit
    sprite_hit_detect #(
      .SPR_W(SPR_W), .SPR_H(SPR_H), .POS_W(POS_W), .CNT_W(CNT_W)
    ) u_hit (
      .clk   (clk),
      .rst   (rst),
      .en    (act_en[i]),
      .x     (act_x[i*POS_W +: POS_W]),
      .y     (act_y[i*POS_W +: POS_W]),
      .hcount(in_hcount),
      .vcount(in_vcount),
      .blank (in_hblnk | in_vblnk),
      .hit   (hit[i])
    );
  end

  // Walk from the highest index down so sprite 0 wins any overlap.
  always_comb begin
    sel_rgb = rgb_d;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) sel_rgb = sprite_rgb[i*RGB_W +: RGB_W];
    end
    multi = |(hit & (hit - N_SPRITES'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev    <= 1'b0;
      frame_tick <= 1'b0;
      act_x      <= '0;
      act_y      <= '0;
      act_en     <= '0;
      acc        <= '0;
      collision  <= '0;
      hcount_d   <= '0;
      vcount_d   <= '0;
      hsync_d    <= 1'b0;
      vsync_d    <= 1'b0;
      hblnk_d    <= 1'b0;
      vblnk_d    <= 1'b0;
      rgb_d      <= '0;
      out_hcount <= '0;
      out_vcount <= '0;
      out_hsync  <= 1'b0;
      out_vsync  <= 1'b0;
      out_hblnk  <= 1'b0;
      out_vblnk  <= 1'b0;
      out_rgb    <= '0;
    end else begin
      vs_prev    <= in_vsync;
      frame_tick <= latch;
      if (latch) begin
        act_x     <= xpos;
        act_y     <= ypos;
        act_en    <= sprite_en;
        collision <= acc;
      end
      // Clear on the latch first, then merge any overlap seen this cycle.
      acc <= (latch ? '0 : acc) | (multi ? hit : '0);

      hcount_d   <= in_hcount;
      vcount_d   <= in_vcount;
      hsync_d    <= in_hsync;
      vsync_d    <= in_vsync;
      hblnk_d    <= in_hblnk;
      vblnk_d    <= in_vblnk;
      rgb_d      <= in_rgb;

      out_hcount <= hcount_d;
      out_vcount <= vcount_d;
      out_hsync  <= hsync_d;
      out_vsync  <= vsync_d;
      out_hblnk  <= hblnk_d;
      out_vblnk  <= vblnk_d;
      out_rgb    <= sel_rgb;
    end
  end
endmodule
